// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: sweeps DEPTH words, writes back single/WP-corrected codewords, yields to the host.
// Optional sticky uncorrectable-error interrupt enabled by defining ECC_SCRUB_IRQ_EN.
module ecc_scrub_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              host_req,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [12:0]       mem_wdata,
  input  logic [12:0]       mem_rdata,
  output logic [12:0]       dec_in,
  input  logic [3:0]        dec_syndrome,
  input  logic [1:0]        dec_err_type,
  output logic              busy,
  output logic              done,
  output logic [7:0]        corr_cnt,
  output logic [7:0]        uncorr_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic              irq,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [12:0]       cw_q, cw_d;
  logic [12:0]       fix_q, fix_d;
  logic              busy_q, busy_d;
  logic [7:0]        corr_q, corr_d;
  logic [7:0]        uncorr_q, uncorr_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              irq_set, irq_clr;
  logic              advance, go_write, uncorr;
  logic [12:0]       flipped;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cw_d       = cw_q;
    fix_d      = fix_q;
    busy_d     = busy_q;
    corr_d     = corr_q;
    uncorr_d   = uncorr_q;
    err_addr_d = err_addr_q;
    irq_set    = 1'b0;
    irq_clr    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    done       = 1'b0;
    advance    = 1'b0;
    go_write   = 1'b0;
    uncorr     = 1'b0;
    flipped    = cw_q;

    if (abort && (state_q != S_IDLE)) begin
      // Abort drops the sweep; counters and err_addr keep their values.
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d  = S_READ;
            addr_d   = '0;
            corr_d   = 8'd0;
            uncorr_d = 8'd0;
            busy_d   = 1'b1;
            irq_clr  = 1'b1;
          end
        end
        S_READ: begin
          if (!host_req) begin
            mem_rd  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          cw_d    = mem_rdata;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          case (dec_err_type)
            2'b00: advance = 1'b1;
            2'b01: begin
              fix_d    = cw_q ^ 13'h1000;
              go_write = 1'b1;
            end
            2'b10: begin
              if (dec_syndrome >= 4'd1 && dec_syndrome <= 4'd12) begin
                // Syndrome is the 1-based bit position; WP is rebuilt from the repaired bits.
                flipped  = cw_q ^ (13'd1 << (dec_syndrome - 4'd1));
                fix_d    = {^flipped[11:0], flipped[11:0]};
                go_write = 1'b1;
              end else begin
                uncorr = 1'b1;
              end
            end
            default: uncorr = 1'b1;
          endcase
          if (go_write) begin
            state_d = S_WRITE;
            corr_d  = sat_inc(corr_q);
          end
          if (uncorr) begin
            uncorr_d   = sat_inc(uncorr_q);
            err_addr_d = addr_q;
            irq_set    = 1'b1;
            advance    = 1'b1;
          end
        end
        S_WRITE: begin
          if (!host_req) begin
            mem_wr  = 1'b1;
            advance = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (advance) begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done    = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_READ;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cw_q       <= '0;
      fix_q      <= '0;
      busy_q     <= 1'b0;
      corr_q     <= 8'd0;
      uncorr_q   <= 8'd0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cw_q       <= cw_d;
      fix_q      <= fix_d;
      busy_q     <= busy_d;
      corr_q     <= corr_d;
      uncorr_q   <= uncorr_d;
      err_addr_q <= err_addr_d;
    end
  end

`ifdef ECC_SCRUB_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       irq_q <= 1'b0;
    else if (irq_clr) irq_q <= 1'b0;
    else if (irq_set) irq_q <= 1'b1;
  end
  assign irq = irq_q;
`else
  logic irq_unused;
  assign irq_unused = irq_set | irq_clr;
  assign irq        = 1'b0;
`endif

  assign host_gnt    = host_req & (state_q != S_WAIT);
  assign mem_addr    = addr_q;
  assign mem_wdata   = (state_q == S_WRITE) ? fix_q : 13'd0;
  assign dec_in      = cw_q;
  assign busy        = busy_q;
  assign corr_cnt    = corr_q;
  assign uncorr_cnt  = uncorr_q;
  assign err_addr    = err_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DEPTH, default 256, number of words swept (1..2^ADDR_W).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge; one clock, reset asynchronous active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start / abort  input  1 each  one-cycle sweep start / stop requests.
REQ-006 SHALL have port host_req  input  1  host wants the memory port this cycle; host_gnt  output  1  host owns the port.
REQ-007 SHALL have port mem_addr  output  ADDR_W;  mem_rd, mem_wr  output  1 each;  mem_wdata  output  13;  mem_rdata  input  13 (WP in bit 12, Hamming bits 11:0).
REQ-008 SHALL have port dec_in  output  13  codeword to external SECDED decoder; dec_syndrome  input  4;  dec_err_type  input  2 (00 none, 01 WP, 10 single, 11 multi).
REQ-009 SHALL have port busy, done  output  1 each;  corr_cnt, uncorr_cnt  output  8 each;  err_addr  output  ADDR_W;  irq  output  1.

Function
REQ-010 SHALL implement FSM IDLE -> READ -> WAIT -> CHECK -> {WRITE | READ | IDLE}; WRITE -> {READ | IDLE}.
REQ-011 SHALL leave IDLE on start=1 & abort=0: addr<=0, corr_cnt<=0, uncorr_cnt<=0, busy<=1; start while busy ignored.
REQ-012 SHALL, in READ with host_req=0, drive mem_rd=1, mem_addr=addr, go WAIT; with host_req=1 hold READ, mem_rd=0.
REQ-013 SHALL, in WAIT, register mem_rdata into cw (read latency exactly 1 cycle), go CHECK.
REQ-014 SHALL drive dec_in=cw continuously; sample dec_syndrome/dec_err_type combinationally in CHECK.
REQ-015 SHALL, in CHECK: type 00 -> no write; type 01 -> fix=cw with bit 12 inverted, go WRITE; type 10 with syndrome 1..12 -> fix=cw with bit (syndrome-1) inverted then bit 12 = XOR of fix[11:0], go WRITE; type 11, or type 10 with syndrome 0/13..15 -> uncorrectable, no write.
REQ-016 SHALL increment corr_cnt on each WRITE entry and uncorr_cnt on each uncorrectable; both saturate at 255; err_addr<=addr on uncorrectable.
REQ-017 SHALL, in WRITE with host_req=0, drive mem_wr=1, mem_addr=addr, mem_wdata=fix; with host_req=1 hold WRITE, mem_wr=0.
REQ-018 SHALL, after CHECK (no write) or WRITE issue: if addr==DEPTH-1 go IDLE, busy<=0, done=1 for one cycle; else addr<=addr+1, go READ.
REQ-019 SHALL drive host_gnt = host_req & (state != WAIT); mem_rd/mem_wr never both 1; neither asserted when host_gnt=1.
REQ-020 SHALL, on abort=1 in any non-IDLE state, go IDLE next cycle, busy<=0, no done, no mem_wr that cycle; counters and err_addr retained; abort wins over simultaneous start.
REQ-021 SHALL keep mem_rd, mem_wr, done 0 in IDLE; mem_wdata=0 except in WRITE.

Reset
REQ-022 SHALL, on rst_n=0 (asynchronously, any state): state=IDLE, addr=0, cw=0, busy=0, done=0, mem_rd=0, mem_wr=0, corr_cnt=0, uncorr_cnt=0, err_addr=0, irq=0.
REQ-023 SHALL leave reset synchronously with the first clk edge after rst_n rises; reset mid-sweep discards sweep, no write issued.

Configuration
REQ-024 SHALL, with ECC_SCRUB_IRQ_EN defined, set irq sticky 1 on every uncorrectable word and clear it only on start or reset.
REQ-025 SHALL, without ECC_SCRUB_IRQ_EN, tie irq to 0 and omit its register; all other behaviour identical.

Verification
REQ-026 SHALL cover clean memory, DEPTH=4: start -> 4 reads, 0 writes, done after 12 cycles of READ/WAIT/CHECK, corr_cnt=0.
REQ-027 SHALL cover addr 2 codeword with bit 4 flipped, decoder returns syndrome 5/type 10 -> mem_wr at addr 2, wdata = original codeword, corr_cnt=1.
REQ-028 SHALL cover addr 1 type 11 -> no write, uncorr_cnt=1, err_addr=1, irq=1 (macro on) / 0 (off).
REQ-029 SHALL cover host_req held 3 cycles during READ and WRITE -> host_gnt=1, state held, no mem_rd/mem_wr, sweep resumes correctly.
REQ-030 SHALL cover abort in WRITE and rst_n low in WAIT -> IDLE, no write, busy=0, done never pulses; 300 single-bit errors -> corr_cnt=255.
